// File: rtl/regfile_mp.sv
// regfile_mp: 2-write-port register file with a registered dual read port
// and a per-register pending scoreboard.
//
// Parameters: DATA_W (data width), ADDR_W (address width, DEPTH = 2**ADDR_W),
//             ZERO_REG (1: register 0 reads zero, drops writes, never pending).
// Optional:   define REGFILE_BYPASS_EN to forward same-edge write data to a
//             read of the same address. Without it such a read returns the
//             value stored before that edge.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   regwrite0/1, write_reg0/1,
//   write_data0/1                   write ports (port 1 wins on address clash)
//   rd_en, read_reg1/2              read request and addresses
//   read_data1/2, read_valid        registered read data, one-cycle valid pulse
//   mark_en, mark_reg               set pending bit of mark_reg
//   pend1/pend2                     combinational pending bit of read_reg1/2
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite0,
  input  logic              regwrite1,
  input  logic [ADDR_W-1:0] write_reg0,
  input  logic [ADDR_W-1:0] write_reg1,
  input  logic [DATA_W-1:0] write_data0,
  input  logic [DATA_W-1:0] write_data1,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              read_valid,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_reg,
  output logic              pend1,
  output logic              pend2
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_next;
  logic [DATA_W-1:0] rdata1_next;
  logic [DATA_W-1:0] rdata2_next;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Storage. Port 1 is assigned last so it wins an address clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (regwrite0 && !is_zero(write_reg0)) regs[write_reg0] <= write_data0;
      if (regwrite1 && !is_zero(write_reg1)) regs[write_reg1] <= write_data1;
    end
  end

  // Read data selection, evaluated before the edge that loads it.
  always_comb begin
    rdata1_next = regs[read_reg1];
    rdata2_next = regs[read_reg2];
`ifdef REGFILE_BYPASS_EN
    if (regwrite1 && write_reg1 == read_reg1)      rdata1_next = write_data1;
    else if (regwrite0 && write_reg0 == read_reg1) rdata1_next = write_data0;
    if (regwrite1 && write_reg1 == read_reg2)      rdata2_next = write_data1;
    else if (regwrite0 && write_reg0 == read_reg2) rdata2_next = write_data0;
`endif
    if (is_zero(read_reg1)) rdata1_next = '0;
    if (is_zero(read_reg2)) rdata2_next = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data1 <= '0;
      read_data2 <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= rd_en;
      if (rd_en) begin
        read_data1 <= rdata1_next;
        read_data2 <= rdata2_next;
      end
    end
  end

  // Writes retire the producer; a mark applied after the clears means a new
  // producer issued on the same edge keeps the register pending.
  always_comb begin
    pending_next = pending;
    if (regwrite0) pending_next[write_reg0] = 1'b0;
    if (regwrite1) pending_next[write_reg1] = 1'b0;
    if (mark_en)   pending_next[mark_reg]   = 1'b1;
    if (ZERO_REG != 0) pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

  assign pend1 = pending[read_reg1];
  assign pend2 = pending[read_reg2];

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed scenarios plus randomized traffic,
// checked against a behavioural model built from arrays.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          regwrite0, regwrite1;
  logic [AW-1:0] write_reg0, write_reg1;
  logic [DW-1:0] write_data0, write_data1;
  logic          rd_en;
  logic [AW-1:0] read_reg1, read_reg2;
  logic [DW-1:0] read_data1, read_data2;
  logic          read_valid;
  logic          mark_en;
  logic [AW-1:0] mark_reg;
  logic          pend1, pend2;

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .regwrite0(regwrite0), .regwrite1(regwrite1),
    .write_reg0(write_reg0), .write_reg1(write_reg1),
    .write_data0(write_data0), .write_data1(write_data1),
    .rd_en(rd_en), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2), .read_valid(read_valid),
    .mark_en(mark_en), .mark_reg(mark_reg),
    .pend1(pend1), .pend2(pend2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  logic [DW-1:0] m_rd1, m_rd2;
  bit            m_valid;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_rd1 = '0; m_rd2 = '0; m_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] m_read(input int a);
    logic [DW-1:0] v;
    v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    if (regwrite1 && int'(write_reg1) == a)      v = write_data1;
    else if (regwrite0 && int'(write_reg0) == a) v = write_data0;
`endif
    if (a == 0) v = '0;
    return v;
  endfunction

  // Apply the rules for one rising edge using the inputs currently driven.
  task automatic m_edge();
    m_valid = rd_en;
    if (rd_en) begin
      m_rd1 = m_read(int'(read_reg1));
      m_rd2 = m_read(int'(read_reg2));
    end
    if (regwrite0) begin
      if (write_reg0 != 0) m_mem[write_reg0] = write_data0;
      m_pend[write_reg0] = 1'b0;
    end
    if (regwrite1) begin
      if (write_reg1 != 0) m_mem[write_reg1] = write_data1;
      m_pend[write_reg1] = 1'b0;
    end
    if (mark_en && mark_reg != 0) m_pend[mark_reg] = 1'b1;
  endtask

  task automatic idle();
    regwrite0 = 0; regwrite1 = 0; write_reg0 = '0; write_reg1 = '0;
    write_data0 = '0; write_data1 = '0; rd_en = 0; mark_en = 0; mark_reg = '0;
  endtask

  // Check outputs mid-cycle, then clock one edge and advance the model.
  task automatic step();
    @(negedge clk);
    check_val("read_data1", read_data1, m_rd1);
    check_val("read_data2", read_data2, m_rd2);
    check_val("read_valid", {31'd0, read_valid}, {31'd0, m_valid});
    check_val("pend1", {31'd0, pend1}, {31'd0, m_pend[read_reg1]});
    check_val("pend2", {31'd0, pend2}, {31'd0, m_pend[read_reg2]});
    @(posedge clk);
    m_edge();
    #1;
  endtask

  logic [DW-1:0] held;

  initial begin
    idle();
    read_reg1 = '0; read_reg2 = '0;
    rst = 1'b1;
    m_reset();
    #1;
    check_val("reset_data1", read_data1, '0);
    check_val("reset_valid", {31'd0, read_valid}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset clears data, pending and valid, and overrides same-cycle activity
    regwrite0 = 1; write_reg0 = 6'd4; write_data0 = 32'hFFFF_FFFF;
    mark_en = 1; mark_reg = 6'd4;
    step();
    idle(); mark_en = 1; mark_reg = 6'd4; rd_en = 1; read_reg1 = 6'd4;
    step();
    check_val("pre_rst_pend1", {31'd0, pend1}, 32'd1);
    check_val("pre_rst_data1", read_data1, 32'hFFFF_FFFF);
    #2 rst = 1'b1;
    m_reset();
    #1;
    check_val("rst_data1", read_data1, '0);
    check_val("rst_pend1", {31'd0, pend1}, '0);
    check_val("rst_valid", {31'd0, read_valid}, '0);
    regwrite0 = 1; write_reg0 = 6'd4; write_data0 = 32'hFFFF_FFFF; rd_en = 1;
    @(posedge clk); #1;
    check_val("rst_override", read_data1, '0);
    rst = 1'b0;
    idle(); rd_en = 1; read_reg1 = 6'd4;
    step();
    check_val("rst_read4", read_data1, '0);
    check_val("rst_read4_valid", {31'd0, read_valid}, 32'd1);

    // Dual write to the same address: port 1 wins
    idle();
    regwrite0 = 1; write_reg0 = 6'd5; write_data0 = 32'h1111_1111;
    regwrite1 = 1; write_reg1 = 6'd5; write_data1 = 32'h2222_2222;
    step();
    idle(); rd_en = 1; read_reg1 = 6'd5;
    step();
    check_val("dual_write", read_data1, 32'h2222_2222);

    // Register 0 is hardwired zero and never pending
    idle();
    regwrite0 = 1; write_reg0 = 6'd0; write_data0 = 32'hFFFF_FFFF;
    mark_en = 1; mark_reg = 6'd0;
    step();
    idle(); rd_en = 1; read_reg1 = 6'd0;
    step();
    check_val("zero_data", read_data1, '0);
    check_val("zero_pend", {31'd0, pend1}, '0);

    // Same-edge write and read of reg 7
    idle(); regwrite0 = 1; write_reg0 = 6'd7; write_data0 = 32'hA;
    step();
    idle(); regwrite0 = 1; write_reg0 = 6'd7; write_data0 = 32'hB;
    rd_en = 1; read_reg1 = 6'd7;
    step();
`ifdef REGFILE_BYPASS_EN
    check_val("bypass", read_data1, 32'hB);
`else
    check_val("bypass", read_data1, 32'hA);
`endif

    // Scoreboard set / clear / same-edge set wins
    idle(); read_reg1 = 6'd3; mark_en = 1; mark_reg = 6'd3;
    step();
    check_val("sb_mark", {31'd0, pend1}, 32'd1);
    idle(); regwrite0 = 1; write_reg0 = 6'd3; write_data0 = 32'h33;
    step();
    check_val("sb_clear", {31'd0, pend1}, '0);
    idle(); regwrite1 = 1; write_reg1 = 6'd3; write_data1 = 32'h34;
    mark_en = 1; mark_reg = 6'd3;
    step();
    check_val("sb_mark_write", {31'd0, pend1}, 32'd1);

    // Hold: one read of reg 1, then three cycles of rewrites with rd_en low
    idle(); regwrite0 = 1; write_reg0 = 6'd1; write_data0 = 32'hCAFE_0001;
    step();
    idle(); rd_en = 1; read_reg1 = 6'd1;
    step();
    check_val("hold_first", read_data1, 32'hCAFE_0001);
    check_val("hold_valid_hi", {31'd0, read_valid}, 32'd1);
    held = read_data1;
    for (int k = 0; k < 3; k++) begin
      idle(); regwrite1 = 1; write_reg1 = 6'd1; write_data1 = 32'hBEEF_0000 + k;
      step();
      check_val("hold_data", read_data1, 32'hCAFE_0001);
      check_val("hold_valid_lo", {31'd0, read_valid}, '0);
    end

    // Randomized traffic, addresses often confined to a few registers
    for (int c = 0; c < 600; c++) begin
      bit narrow;
      narrow      = ($urandom_range(0, 3) != 0);
      regwrite0   = ($urandom_range(0, 1) == 1);
      regwrite1   = ($urandom_range(0, 2) == 0);
      write_reg0  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      write_reg1  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      write_data0 = $urandom;
      write_data1 = $urandom;
      rd_en       = ($urandom_range(0, 1) == 1);
      read_reg1   = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      read_reg2   = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      mark_en     = ($urandom_range(0, 2) == 0);
      mark_reg    = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      step();
    end

    idle();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
